// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding, PC step
// and the default reset PC used by the instruction memory map.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  // PC is a word address, so sequential fetch advances by one word.
  localparam int unsigned PC_STEP = 1;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : fetch_pkg

// File: rtl/fetch_sequencer_if.sv
// Bus bundle around the fetch sequencer.
//   imem_req_*  : request channel to instruction memory (valid/ready)
//   imem_rsp_*  : response channel from instruction memory (valid only)
//   inst_*      : instruction channel to decode (valid/ready)
//   redirect_*  : taken branch/jump from execute (target = base + offset)
//   kill_pending: stale response outstanding (observability)
// The sequencer connects through the master modport; memory, decode and
// execute (or a testbench) connect through the slave modport.
interface fetch_sequencer_if #(
  parameter int unsigned XLEN = 32
);

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  logic            inst_valid;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] inst_data;
  logic            inst_ready;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_base;
  logic [XLEN-1:0] redirect_offset;

  logic            kill_pending;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst_pc, inst_data,
    input  inst_ready,
    input  redirect_valid, redirect_base, redirect_offset,
    output kill_pending
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst_pc, inst_data,
    output inst_ready,
    output redirect_valid, redirect_base, redirect_offset,
    input  kill_pending
  );

endinterface : fetch_sequencer_if

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the fetch PC, issues one instruction-memory request
// at a time, presents each returned instruction with its PC to decode and
// applies branch/jump redirects, discarding stale in-flight responses.
//
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : fetch_sequencer_if master (imem req/rsp, inst to decode,
//           redirect from execute, kill_pending)
//
// state | meaning
// IDLE  | post-reset bubble, no request
// REQ   | request for fetch_pc offered to memory
// WAIT  | request accepted, waiting for its response
// HOLD  | instruction presented to decode, waiting for inst_ready
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic                clk,
  input  logic                reset,
  fetch_sequencer_if.master   bus
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic [XLEN-1:0] inst_data_q, inst_data_d;
  logic [XLEN-1:0] target;

  // Both additions wrap modulo 2^XLEN by construction.
  assign target = bus.redirect_base + bus.redirect_offset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      kill_q      <= 1'b0;
      inst_pc_q   <= '0;
      inst_data_q <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      kill_q      <= kill_d;
      inst_pc_q   <= inst_pc_d;
      inst_data_q <= inst_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    kill_d      = kill_q;
    inst_pc_d   = inst_pc_q;
    inst_data_d = inst_data_q;

    case (state_q)
      IDLE: begin
        state_d = REQ;
      end

      REQ: begin
        if (bus.redirect_valid) begin
          fetch_pc_d = target;
        end
        if (bus.imem_req_ready) begin
          state_d = WAIT;
          // The accepted request is for the old PC; its response is stale.
          kill_d  = bus.redirect_valid;
        end
      end

      WAIT: begin
        if (bus.redirect_valid) begin
          fetch_pc_d = target;
        end
        if (bus.imem_rsp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else if (bus.redirect_valid) begin
            state_d = REQ;
          end else begin
            inst_pc_d   = fetch_pc_q;
            inst_data_d = bus.imem_rsp_data;
            state_d     = HOLD;
          end
        end else if (bus.redirect_valid) begin
          kill_d = 1'b1;
        end
      end

      HOLD: begin
        // A redirect retires the held instruction even if decode stalls.
        if (bus.redirect_valid) begin
          fetch_pc_d = target;
          state_d    = REQ;
        end else if (bus.inst_ready) begin
          fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
          state_d    = REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Address is gated so the bus reads zero outside REQ (including reset).
  assign bus.imem_req_valid = (state_q == REQ);
  assign bus.imem_req_addr  = (state_q == REQ) ? fetch_pc_q : '0;
  assign bus.inst_valid     = (state_q == HOLD);
  assign bus.inst_pc        = inst_pc_q;
  assign bus.inst_data      = inst_data_q;
  assign bus.kill_pending   = kill_q;

endmodule : fetch_sequencer
